prog_loader_imem: RTL
=====================

PROG_LOADER_IMEM -- requirements
Module: prog_loader_imem

Interface
REQ-001 SHALL have parameter W, default 16: instruction word width.
REQ-002 SHALL have parameter AW, default 8 (W-8): instruction address width, depth 2^AW words.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port load_start, input, 1: one-cycle request to begin a program load.
REQ-006 SHALL have port in_byte, input, 8: load stream byte.
REQ-007 SHALL have port in_valid, input, 1: in_byte valid.
REQ-008 SHALL have port in_ready, output, 1: loader accepts a byte this cycle.
REQ-009 SHALL have port fetch_addr, input, AW: CPU program-counter address (PC_addr).
REQ-010 SHALL have port fetch_data, output, W: registered instruction word for the CPU.
REQ-011 SHALL have port cpu_rst, output, 1: holds the CPU core in reset while not running.
REQ-012 SHALL have port words_loaded, output, AW+1: count of words written in the current/last load.
REQ-013 SHALL have port busy, output, 1: high while a load is in progress.

Function
REQ-014 SHALL implement states IDLE, HDR, HI, LO, RUN; byte accepted only when in_valid && in_ready.
REQ-015 SHALL drive in_ready = 1 in HDR, HI, LO; 0 in IDLE, RUN.
REQ-016 SHALL, from IDLE or RUN, go to HDR on load_start, clearing words_loaded to 0 on the same edge.
REQ-017 SHALL ignore load_start while in HDR, HI or LO.
REQ-018 SHALL, in HDR, latch the accepted byte as word count N (0 encodes 256; for AW<8, value limited to 2^AW) and go to HI.
REQ-019 SHALL, in HI, latch the accepted byte as the high byte of the word and go to LO.
REQ-020 SHALL, in LO, write {high, accepted byte} to mem[words_loaded[AW-1:0]], increment words_loaded, and go to HI, or go to RUN if this was word N.
REQ-021 SHALL hold state and all registers when no byte is accepted (in_valid low); no timeout.
REQ-022 SHALL register cpu_rst = 1 whenever the next state is not RUN: low on the first cycle in RUN, high the cycle after load_start leaves RUN.
REQ-023 SHALL register fetch_data <= mem[fetch_addr] in RUN (1-cycle read latency) and <= 0 in every other state.
REQ-024 SHALL leave memory words beyond N unchanged from prior contents; no clearing.
REQ-025 SHALL drive busy = 1 in HDR, HI, LO only.
REQ-026 SHALL never write memory and read for fetch in the same cycle; writes occur only in LO, fetches only in RUN.

Reset
REQ-027 SHALL, on reset assertion, immediately force state IDLE, cpu_rst = 1, in_ready = 0, busy = 0, fetch_data = 0, words_loaded = 0.
REQ-028 SHALL not reset memory contents; a reset mid-load abandons the load, keeping already-written words.
REQ-029 SHALL leave IDLE only on load_start after reset deassertion.

Verification
REQ-030 Basic load: load_start, bytes 0x02,0x12,0x34,0xAB,0xCD -> mem[0]=0x1234, mem[1]=0xABCD, words_loaded=2, cpu_rst low first RUN cycle; fetch_addr=1 -> fetch_data=0xABCD one cycle later.
REQ-031 Backpressure: in_valid toggled 1/0 each cycle over the same stream -> identical memory result, state frozen on in_valid=0 cycles.
REQ-032 Full depth: header 0x00 then 512 bytes of incrementing words 0x0000..0x00FF -> words_loaded=256, mem[255]=0x00FF, RUN entered after byte 513.
REQ-033 Reload from RUN: load_start while running -> cpu_rst high next cycle, fetch_data=0, new N=1 word 0xBEEF lands at mem[0], mem[1] retains 0xABCD.
REQ-034 Reset mid-load: assert reset after header and one high byte -> asynchronous return to IDLE, cpu_rst=1, words_loaded=0, in_ready=0; load_start ignored during HI/LO confirmed separately.

Source files
------------

// File: rtl/prog_loader_imem.sv
// Byte-stream program loader for a CPU instruction memory: a header byte gives the word
// count, then each word arrives high byte first; the CPU is released once the last word lands.
//  state | meaning
//  IDLE  | after reset, waiting for load_start
//  HDR   | waiting for word-count byte
//  HI    | waiting for high byte of next word
//  LO    | waiting for low byte; writes the word
//  RUN   | program loaded, CPU running and fetching
module prog_loader_imem #(
    parameter int W  = 16,
    parameter int AW = W - 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic [7:0]    in_byte,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] fetch_addr,
    output logic [W-1:0]  fetch_data,
    output logic          cpu_rst,
    output logic [AW:0]   words_loaded,
    output logic          busy
);
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_HI, S_LO, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   n_q, n_d;
    logic [7:0]    hi_q, hi_d;
    logic [AW:0]   words_loaded_q, words_loaded_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic [W-1:0]  fetch_data_q, fetch_data_d;
    logic          accept;
    logic          mem_we;
    logic [AW:0]   hdr_n;
    logic [31:0]   hdr_full;
    logic [AW:0]   wl_inc;
    logic [W-1:0]  mem [DEPTH];

    assign in_ready     = (state_q == S_HDR) || (state_q == S_HI) || (state_q == S_LO);
    assign busy         = in_ready;
    assign accept       = in_valid && in_ready;
    assign cpu_rst      = cpu_rst_q;
    assign fetch_data   = fetch_data_q;
    assign words_loaded = words_loaded_q;
    assign wl_inc       = words_loaded_q + (AW+1)'(1);

    // Header 0 means 256 words; narrow memories clamp to their depth.
    always_comb begin
        hdr_full = (in_byte == 8'd0) ? 32'd256 : {24'd0, in_byte};
        if (hdr_full > DEPTH) hdr_full = DEPTH;
        hdr_n = (AW+1)'(hdr_full);
    end

    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        hi_d           = hi_q;
        words_loaded_d = words_loaded_q;
        mem_we         = 1'b0;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (load_start) begin
                    state_d        = S_HDR;
                    words_loaded_d = '0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    n_d     = hdr_n;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    hi_d    = in_byte;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    mem_we         = 1'b1;
                    words_loaded_d = wl_inc;
                    state_d        = (wl_inc == n_q) ? S_RUN : S_HI;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cpu_rst_d    = (state_d != S_RUN);
        fetch_data_d = (state_q == S_RUN) ? mem[fetch_addr] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            n_q            <= '0;
            hi_q           <= '0;
            words_loaded_q <= '0;
            cpu_rst_q      <= 1'b1;
            fetch_data_q   <= '0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            hi_q           <= hi_d;
            words_loaded_q <= words_loaded_d;
            cpu_rst_q      <= cpu_rst_d;
            fetch_data_q   <= fetch_data_d;
        end
    end

    // Memory survives reset so an abandoned load keeps the words it already wrote.
    always_ff @(posedge clk) begin
        if (mem_we) mem[words_loaded_q[AW-1:0]] <= W'({hi_q, in_byte});
    end

endmodule
